// File: rtl/if_fetch_stage_pkg.sv
// Shared constants for the instruction-fetch slice.
//   WORD_WIDTH      : architectural word width.
//   RESET_PC_VALUE  : default PC loaded on reset.
//   NPC_OP_*        : next-PC operation encodings used by the next-PC logic.
//   word_align()    : clears the byte-offset bits of an address.
package if_fetch_stage_pkg;

    localparam int WORD_WIDTH = 32;
    localparam logic [WORD_WIDTH-1:0] RESET_PC_VALUE = 32'h0000_3000;

    localparam logic [1:0] NPC_OP_SEQ    = 2'd0;
    localparam logic [1:0] NPC_OP_BRANCH = 2'd1;
    localparam logic [1:0] NPC_OP_JAL    = 2'd2;
    localparam logic [1:0] NPC_OP_JALR   = 2'd3;

    function automatic logic [WORD_WIDTH-1:0] word_align(input logic [WORD_WIDTH-1:0] addr);
        return {addr[WORD_WIDTH-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch_stage_fetch_fifo.sv
// fetch_fifo: parameterised circular FIFO with synchronous reset and clear.
//   clk, rst         : clock, synchronous active-high reset
//   clear            : empties the FIFO this cycle (wins over push/pop)
//   push, push_data  : write an entry (ignored when full)
//   pop              : drop the head entry (ignored when empty)
//   head_data        : current head entry, straight from the storage array
//   count/full/empty : occupancy
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [CW-1:0]    cnt;
    logic             do_push;
    logic             do_pop;

    assign full      = (cnt == CW'(DEPTH));
    assign empty     = (cnt == '0);
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign head_data = mem[rd_ptr];
    assign count     = cnt;

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: holds the PC, issues word fetches over req/gnt/rvalid and
// buffers returned instructions in an in-order queue feeding decode.
//   clk, rst                      : clock, synchronous active-high reset
//   redirect_i, redirect_pc_i     : flush and restart fetch at a new PC
//   imem_req_o, imem_addr_o       : fetch request, held until granted
//   imem_gnt_i                    : request accepted (req && gnt = issue)
//   imem_rvalid_i, imem_rdata_i   : in-order responses, >= 1 cycle after grant
//   id_valid_o, id_ready_i        : decode handshake
//   id_pc_o, id_pc4_o, id_inst_o  : head instruction, its PC and PC + 4
//
// Handshakes: a transfer happens in any cycle where valid (req) and ready
// (gnt) are both high at the rising edge; a source that raises valid keeps
// it and its payload stable until the transfer, and ready may depend
// combinationally on valid but never the other way round.
module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_VALUE,
    parameter int          FQ_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        id_valid_o,
    input  logic        id_ready_i,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_pc4_o,
    output logic [31:0] id_inst_o
);

    localparam int CW = $clog2(FQ_DEPTH) + 1;
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(FQ_DEPTH);

    logic [31:0]   pc_q;
    logic [CW-1:0] outstanding_q;
    logic [CW-1:0] discard_q;

    logic [CW-1:0] q_count;
    logic          q_full;
    logic          q_empty;
    logic [63:0]   q_head;
    logic          q_push;
    logic          q_pop;

    logic [CW-1:0] tag_count;
    logic          tag_full;
    logic          tag_empty;
    logic [31:0]   tag_head;

    logic          issue;
    logic [CW:0]   credit;

    // A response is dropped while older requests remain to be discarded or
    // when it lands in the redirect cycle itself.
    assign q_push = imem_rvalid_i && !redirect_i && (discard_q == '0);
    assign q_pop  = id_valid_o && id_ready_i && !redirect_i;

    // The slot freed by this cycle's pop is credited immediately; without it
    // single-cycle memory would only sustain one fetch every other cycle.
    assign credit = {1'b0, outstanding_q} + {1'b0, q_count} - {{CW{1'b0}}, q_pop};

    assign imem_req_o  = !rst && !redirect_i && (credit < DEPTH_C);
    assign imem_addr_o = pc_q;
    assign issue       = imem_req_o && imem_gnt_i;

    assign id_valid_o = !rst && !q_empty;
    assign id_pc_o    = id_valid_o ? q_head[63:32] : 32'h0;
    assign id_pc4_o   = id_valid_o ? q_head[63:32] + 32'd4 : 32'h0;
    assign id_inst_o  = id_valid_o ? q_head[31:0] : 32'h0;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            outstanding_q <= outstanding_q + CW'(issue) - CW'(imem_rvalid_i);
            if (redirect_i) begin
                pc_q <= word_align(redirect_pc_i);
                // outstanding_q already covers any pending discards, so it
                // alone is the number of responses still to be thrown away.
                discard_q <= outstanding_q - CW'(imem_rvalid_i);
            end else begin
                if (issue) begin
                    pc_q <= pc_q + 32'd4;
                end
                if (imem_rvalid_i && (discard_q != '0)) begin
                    discard_q <= discard_q - CW'(1);
                end
            end
        end
    end

    fetch_fifo #(.WIDTH(64), .DEPTH(FQ_DEPTH)) u_inst_q (
        .clk       (clk),
        .rst       (rst),
        .clear     (redirect_i),
        .push      (q_push),
        .push_data ({tag_head, imem_rdata_i}),
        .pop       (q_pop),
        .head_data (q_head),
        .count     (q_count),
        .full      (q_full),
        .empty     (q_empty)
    );

    // Addresses of live (non-discarded) requests, oldest first.
    fetch_fifo #(.WIDTH(32), .DEPTH(FQ_DEPTH)) u_tag_q (
        .clk       (clk),
        .rst       (rst),
        .clear     (redirect_i),
        .push      (issue),
        .push_data (pc_q),
        .pop       (q_push),
        .head_data (tag_head),
        .count     (tag_count),
        .full      (tag_full),
        .empty     (tag_empty)
    );

    a_q_no_overflow: assert property (@(posedge clk) disable iff (rst) !(q_push && q_full));
    a_tag_no_overflow: assert property (@(posedge clk) disable iff (rst) !(issue && tag_full));
    a_tag_no_underflow: assert property (@(posedge clk) disable iff (rst) !(q_push && tag_empty));
    a_tag_tracks_live: assert property (@(posedge clk) disable iff (rst)
        tag_count == outstanding_q - discard_q);

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: directed phases against a small
// in-order memory model, an expected-issue queue and an expected-decode queue.
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        id_valid_o;
    logic        id_ready_i;
    logic [31:0] id_pc_o;
    logic [31:0] id_pc4_o;
    logic [31:0] id_inst_o;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int lat   = 1;
    bit strict = 1'b0;

    logic [31:0] exp_q[$];      // expected decode PCs, in order
    logic [31:0] iss_q[$];      // expected issued addresses, in order
    logic [31:0] mem_addr_q[$]; // memory model: granted addresses
    int          mem_due_q[$];  // memory model: cycle the response is due

    if_fetch_stage dut (
        .clk           (clk),
        .rst           (rst),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .id_valid_o    (id_valid_o),
        .id_ready_i    (id_ready_i),
        .id_pc_o       (id_pc_o),
        .id_pc4_o      (id_pc4_o),
        .id_inst_o     (id_inst_o)
    );

    // clock
    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] addr);
        return {addr[15:0], ~addr[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock: entered just after a falling edge with inputs set, returns
    // at the next falling edge with the memory response for that cycle driven.
    task automatic cycle();
        logic        iss;
        logic        rv;
        logic        hs;
        logic [31:0] a;
        logic [31:0] e;
        #1;
        iss = imem_req_o && imem_gnt_i;
        a   = imem_addr_o;
        rv  = imem_rvalid_i;
        hs  = id_valid_o && id_ready_i;
        if (iss) begin
            if (iss_q.size() > 0) chk("issue_addr", a, iss_q.pop_front());
            else if (strict) chk("unexpected_issue", 32'(iss), 32'h0);
        end
        if (hs) begin
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("id_pc", id_pc_o, e);
                chk("id_pc4", id_pc4_o, e + 32'd4);
                chk("id_inst", id_inst_o, inst_of(e));
            end else if (strict) begin
                chk("unexpected_pop", id_pc_o, 32'hDEAD_BEEF);
            end
        end
        @(posedge clk);
        if (!rst) begin
            if (rv && mem_addr_q.size() > 0) begin
                void'(mem_addr_q.pop_front());
                void'(mem_due_q.pop_front());
            end
            if (iss) begin
                mem_addr_q.push_back(a);
                mem_due_q.push_back(cyc + lat);
            end
        end
        cyc++;
        @(negedge clk);
        if (mem_addr_q.size() > 0 && mem_due_q[0] <= cyc) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = inst_of(mem_addr_q[0]);
        end else begin
            imem_rvalid_i = 1'b0;
            imem_rdata_i  = 32'h0;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    // Two reset cycles; memory is reset alongside, so nothing in flight survives.
    task automatic do_reset();
        rst        = 1'b1;
        redirect_i = 1'b0;
        exp_q.delete();
        iss_q.delete();
        mem_addr_q.delete();
        mem_due_q.delete();
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = 32'h0;
        cycle();
        #1;
        chk("rst_req", 32'(imem_req_o), 32'h0);
        chk("rst_valid", 32'(id_valid_o), 32'h0);
        chk("rst_pc", id_pc_o, 32'h0);
        chk("rst_pc4", id_pc4_o, 32'h0);
        chk("rst_inst", id_inst_o, 32'h0);
        cycle();
        rst = 1'b0;
    endtask

    task automatic drained(input string tag);
        chk({tag, "_iss_left"}, 32'(iss_q.size()), 32'h0);
        chk({tag, "_exp_left"}, 32'(exp_q.size()), 32'h0);
    endtask

    initial begin
        rst           = 1'b1;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = 32'h0;
        id_ready_i    = 1'b0;
        @(negedge clk);

        // Streaming: single-cycle memory, decode always ready.
        imem_gnt_i = 1'b1; id_ready_i = 1'b1; lat = 1; strict = 1'b0;
        do_reset();
        for (int i = 0; i < 8; i++) iss_q.push_back(32'h3000 + 32'(4 * i));
        for (int i = 0; i < 6; i++) exp_q.push_back(32'h3000 + 32'(4 * i));
        #1;
        chk("s_req0", 32'(imem_req_o), 32'h1);
        chk("s_addr0", imem_addr_o, 32'h3000);
        chk("s_valid0", 32'(id_valid_o), 32'h0);
        cycle();
        #1 chk("s_valid1", 32'(id_valid_o), 32'h0);
        cycle();
        #1;
        chk("s_valid2", 32'(id_valid_o), 32'h1);
        chk("s_pc2", id_pc_o, 32'h3000);
        run(6);
        drained("stream");

        // Stall: decode not ready for 5 cycles.
        id_ready_i = 1'b0; strict = 1'b1;
        do_reset();
        iss_q.push_back(32'h3000); iss_q.push_back(32'h3004);
        run(2);
        #1 chk("st_req_drop", 32'(imem_req_o), 32'h0);
        run(2);
        #1;
        chk("st_req_held", 32'(imem_req_o), 32'h0);
        chk("st_valid", 32'(id_valid_o), 32'h1);
        chk("st_head_pc", id_pc_o, 32'h3000);
        chk("st_head_inst", id_inst_o, inst_of(32'h3000));
        cycle();
        id_ready_i = 1'b1;
        exp_q.push_back(32'h3000); exp_q.push_back(32'h3004); exp_q.push_back(32'h3008);
        iss_q.push_back(32'h3008); iss_q.push_back(32'h300C); iss_q.push_back(32'h3010);
        run(3);
        drained("stall");

        // Redirect with two late responses outstanding.
        id_ready_i = 1'b1; lat = 3;
        do_reset();
        iss_q.push_back(32'h3000); iss_q.push_back(32'h3004);
        iss_q.push_back(32'h4000); iss_q.push_back(32'h4004);
        iss_q.push_back(32'h4008); iss_q.push_back(32'h400C);
        exp_q.push_back(32'h4000); exp_q.push_back(32'h4004);
        run(2);
        #1 chk("rd_req_full", 32'(imem_req_o), 32'h0);
        redirect_i = 1'b1; redirect_pc_i = 32'h0000_4003;
        cycle();
        redirect_i = 1'b0;
        #1;
        chk("rd_addr_new", imem_addr_o, 32'h4000);
        chk("rd_req_wait", 32'(imem_req_o), 32'h0);
        run(7);
        drained("redir");

        // Redirect coinciding with a response while decode stalls.
        id_ready_i = 1'b0; lat = 1;
        do_reset();
        iss_q.push_back(32'h3000); iss_q.push_back(32'h3004);
        iss_q.push_back(32'h5000); iss_q.push_back(32'h5004);
        iss_q.push_back(32'h5008); iss_q.push_back(32'h500C);
        run(2);
        #1;
        chk("rr_valid_pre", 32'(id_valid_o), 32'h1);
        chk("rr_rvalid_pre", 32'(imem_rvalid_i), 32'h1);
        redirect_i = 1'b1; redirect_pc_i = 32'h0000_5000;
        #1 chk("rr_req_redir", 32'(imem_req_o), 32'h0);
        cycle();
        redirect_i = 1'b0;
        #1;
        chk("rr_valid_clr", 32'(id_valid_o), 32'h0);
        chk("rr_req_new", 32'(imem_req_o), 32'h1);
        chk("rr_addr_new", imem_addr_o, 32'h5000);
        id_ready_i = 1'b1;
        exp_q.push_back(32'h5000); exp_q.push_back(32'h5004);
        run(4);
        drained("redir_rv");

        // Grant back-pressure.
        imem_gnt_i = 1'b0; id_ready_i = 1'b1; lat = 1;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("gp_req", 32'(imem_req_o), 32'h1);
            chk("gp_addr", imem_addr_o, 32'h3000);
            cycle();
        end
        imem_gnt_i = 1'b1;
        iss_q.push_back(32'h3000); iss_q.push_back(32'h3004);
        iss_q.push_back(32'h3008); iss_q.push_back(32'h300C);
        exp_q.push_back(32'h3000); exp_q.push_back(32'h3004);
        run(4);
        drained("gnt");

        // PC wrap, then reset with requests in flight.
        imem_gnt_i = 1'b1; id_ready_i = 1'b1; lat = 2;
        do_reset();
        iss_q.push_back(32'hFFFF_FFFC); iss_q.push_back(32'h0000_0000);
        redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
        #1 chk("wr_req_redir", 32'(imem_req_o), 32'h0);
        cycle();
        redirect_i = 1'b0;
        #1;
        chk("wr_req", 32'(imem_req_o), 32'h1);
        chk("wr_addr", imem_addr_o, 32'hFFFF_FFFC);
        run(2);
        #1 chk("wr_addr_wrapped", imem_addr_o, 32'h0000_0004);
        chk("wr_iss_left", 32'(iss_q.size()), 32'h0);
        lat = 1;
        do_reset();
        #1;
        chk("wr_post_valid", 32'(id_valid_o), 32'h0);
        chk("wr_post_req", 32'(imem_req_o), 32'h1);
        chk("wr_post_addr", imem_addr_o, 32'h3000);
        iss_q.push_back(32'h3000); iss_q.push_back(32'h3004);
        iss_q.push_back(32'h3008); iss_q.push_back(32'h300C);
        exp_q.push_back(32'h3000); exp_q.push_back(32'h3004);
        run(4);
        drained("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
